// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/PC sequencer: fetches at PC, holds the instruction in IR for the
// skip controller, then picks the next PC from the registered skip/jump/halt decision.
module pc_sequencer #(
    parameter int                  PC_WIDTH  = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int                  CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 Reset_n,
    input  logic                 run,
    output logic                 imem_req,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic                 imem_ready,
    input  logic [15:0]          imem_rdata,
    output logic [15:0]          IR,
    output logic [3:0]           Opcode,
    output logic [3:0]           funct,
    output logic                 ir_valid,
    input  logic                 exec_done,
    input  logic                 skip,
    input  logic                 jump,
    input  logic [PC_WIDTH-1:0]  jump_target,
    input  logic                 halt,
    output logic [PC_WIDTH-1:0]  PC,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] skip_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        UPDATE = 3'd4,
        HALTED = 3'd5
    } state_t;

    state_t              state_q;
    state_t              state_n;
    logic                skip_h;
    logic                jump_h;
    logic                halt_h;
    logic [PC_WIDTH-1:0] target_h;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + CNT_WIDTH'(1);
    endfunction

    always_comb begin
        state_n  = state_q;
        imem_req = 1'b0;
        case (state_q)
            IDLE:    if (run) state_n = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) state_n = DECODE;
            end
            DECODE:  state_n = EXEC;
            EXEC:    if (exec_done) state_n = UPDATE;
            UPDATE: begin
                if (halt_h)   state_n = HALTED;
                else if (run) state_n = FETCH;
                else          state_n = IDLE;
            end
            HALTED:  state_n = HALTED;
            default: state_n = IDLE;
        endcase
    end

    // The decision inputs are only trusted on the exec_done edge, so they are held
    // for the UPDATE cycle rather than read live.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            PC         <= RESET_PC;
            IR         <= '0;
            ir_valid   <= 1'b0;
            skip_count <= '0;
            skip_h     <= 1'b0;
            jump_h     <= 1'b0;
            halt_h     <= 1'b0;
            target_h   <= '0;
        end else begin
            state_q <= state_n;
            case (state_q)
                FETCH: begin
                    if (imem_ready) begin
                        IR       <= imem_rdata;
                        ir_valid <= 1'b1;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        skip_h   <= skip;
                        jump_h   <= jump;
                        halt_h   <= halt;
                        target_h <= jump_target;
                    end
                end
                UPDATE: begin
                    ir_valid <= 1'b0;
                    if (halt_h) begin
                        PC <= PC + PC_WIDTH'(1);
                    end else if (jump_h) begin
                        PC <= target_h;
                    end else if (skip_h) begin
                        PC         <= PC + PC_WIDTH'(2);
                        skip_count <= sat_inc(skip_count);
                    end else begin
                        PC <= PC + PC_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign state     = state_q;
    assign imem_addr = PC;
    assign Opcode    = IR[15:12];
    assign funct     = IR[3:0];

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a behavioural model checked every cycle plus
// hand-computed PC/state/count expectations at key points.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        Reset_n;
    logic        run, imem_ready, exec_done, skip, jump, halt;
    logic [15:0] imem_rdata, jump_target;
    logic        imem_req, ir_valid;
    logic [15:0] imem_addr, IR, PC;
    logic [3:0]  Opcode, funct;
    logic [2:0]  state;
    logic [1:0]  skip_count;

    int tests = 0;
    int fails = 0;

    pc_sequencer #(.PC_WIDTH(16), .RESET_PC(16'h0000), .CNT_WIDTH(2)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .IR(IR), .Opcode(Opcode), .funct(funct),
        .ir_valid(ir_valid), .exec_done(exec_done), .skip(skip), .jump(jump),
        .jump_target(jump_target), .halt(halt), .PC(PC), .state(state),
        .skip_count(skip_count)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: phase number, PC and counters as plain integers.
    int m_st, m_pc, m_ir, m_cnt, h_tgt;
    bit m_valid, h_skip, h_jump, h_halt;

    always @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            m_st <= 0; m_pc <= 0; m_ir <= 0; m_valid <= 0; m_cnt <= 0;
        end else begin
            case (m_st)
                0: if (run) m_st <= 1;
                1: if (imem_ready) begin
                       m_ir <= int'(imem_rdata); m_valid <= 1; m_st <= 2;
                   end
                2: m_st <= 3;
                3: if (exec_done) begin
                       h_skip <= skip; h_jump <= jump; h_halt <= halt;
                       h_tgt <= int'(jump_target); m_st <= 4;
                   end
                4: begin
                       m_valid <= 0;
                       if (h_halt) begin
                           m_pc <= (m_pc + 1) % 65536; m_st <= 5;
                       end else begin
                           if (h_jump)      m_pc <= h_tgt;
                           else if (h_skip) begin
                               m_pc  <= (m_pc + 2) % 65536;
                               m_cnt <= (m_cnt >= 3) ? 3 : m_cnt + 1;
                           end else         m_pc <= (m_pc + 1) % 65536;
                           m_st <= run ? 1 : 0;
                       end
                   end
                5: m_st <= 5;
                default: m_st <= 0;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle; outputs are compared to the model on the falling edge.
    task automatic tick();
        @(negedge CLK);
        check("state",      32'(state),      32'(m_st));
        check("pc",         32'(PC),         32'(m_pc));
        check("imem_addr",  32'(imem_addr),  32'(m_pc));
        check("imem_req",   32'(imem_req),   32'(m_st == 1));
        check("ir",         32'(IR),         32'(m_ir));
        check("opcode",     32'(Opcode),     32'(m_ir / 4096));
        check("funct",      32'(funct),      32'(m_ir % 16));
        check("ir_valid",   32'(ir_valid),   32'(m_valid));
        check("skip_count", 32'(skip_count), 32'(m_cnt));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        Reset_n = 1'b0; run = 0; imem_ready = 0; exec_done = 0;
        skip = 0; jump = 0; halt = 0; imem_rdata = 16'h0; jump_target = 16'h0;
        ticks(2);
        check("rst_state", 32'(state), 32'd0);
        check("rst_pc", 32'(PC), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);

        // Sequential: three instructions after the first fetch
        Reset_n = 1'b1; run = 1; imem_ready = 1; exec_done = 1;
        ticks(13);
        check("seq_pc3", 32'(PC), 32'd3);
        check("seq_state_fetch", 32'(state), 32'd1);

        // Skip at PC=3
        imem_rdata = 16'hD000; skip = 1;
        ticks(2);
        check("skip_opcode_exec", 32'(Opcode), 32'd13);
        check("skip_state_exec", 32'(state), 32'd3);
        ticks(2);
        check("skip_pc5", 32'(PC), 32'd5);
        check("skip_cnt1", 32'(skip_count), 32'd1);

        // Jump wins over skip
        jump = 1; jump_target = 16'h0040;
        ticks(4);
        check("jump_pc40", 32'(PC), 32'h40);
        check("jump_cnt1", 32'(skip_count), 32'd1);
        jump = 0; skip = 0;
        ticks(4);
        check("noskip_pc41", 32'(PC), 32'h41);
        check("noskip_cnt1", 32'(skip_count), 32'd1);

        // Wrap and saturation
        jump = 1; jump_target = 16'hFFFF;
        ticks(4);
        check("jump_pcffff", 32'(PC), 32'hFFFF);
        jump = 0; skip = 1;
        ticks(4);
        check("wrap_pc1", 32'(PC), 32'd1);
        check("wrap_cnt2", 32'(skip_count), 32'd2);
        ticks(8);
        check("sat_pc5", 32'(PC), 32'd5);
        check("sat_cnt3", 32'(skip_count), 32'd3);

        // Fetch stall then exec stall with skip toggling
        skip = 0; imem_ready = 0; imem_rdata = 16'h1234;
        ticks(5);
        check("stall_state", 32'(state), 32'd1);
        check("stall_addr", 32'(imem_addr), 32'd5);
        check("stall_ir", 32'(IR), 32'hD000);
        imem_ready = 1;
        tick();
        imem_ready = 0; exec_done = 0; skip = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            skip = ~skip;
            tick();
        end
        exec_done = 1; skip = 0;
        tick();
        skip = 1;
        tick();
        check("stall_pc6", 32'(PC), 32'd6);
        check("stall_funct", 32'(funct), 32'd4);
        skip = 0;

        // run dropped mid-instruction: completes and parks in IDLE
        run = 0; imem_ready = 1;
        ticks(4);
        check("park_state", 32'(state), 32'd0);
        check("park_pc7", 32'(PC), 32'd7);
        ticks(2);
        check("park_hold_pc7", 32'(PC), 32'd7);

        // Async reset while a fetch is outstanding
        run = 1; imem_ready = 0;
        tick();
        check("fetch_req", 32'(imem_req), 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        check("arst_req", 32'(imem_req), 32'd0);
        check("arst_pc", 32'(PC), 32'd0);
        check("arst_state", 32'(state), 32'd0);
        check("arst_valid", 32'(ir_valid), 32'd0);
        tick();
        Reset_n = 1'b1; imem_ready = 1; imem_rdata = 16'h0000;
        tick();
        check("restart_addr", 32'(imem_addr), 32'd0);
        check("restart_req", 32'(imem_req), 32'd1);
        ticks(20);
        check("restart_pc5", 32'(PC), 32'd5);

        // Halt beats jump and skip
        halt = 1; jump = 1; jump_target = 16'h0040; skip = 1;
        ticks(4);
        check("halt_state", 32'(state), 32'd5);
        check("halt_pc6", 32'(PC), 32'd6);
        check("halt_cnt0", 32'(skip_count), 32'd0);
        halt = 0; jump = 0; skip = 0;
        for (int i = 0; i < 6; i++) begin
            run = ~run;
            tick();
        end
        check("halted_pc6", 32'(PC), 32'd6);
        check("halted_state", 32'(state), 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle fetch/PC sequencer for the accumulator processor.
- Fetches the instruction at PC, holds it in IR, and drives Opcode/funct to the skip-decision controller (miniController).
- Consumes that controller's skip output to choose the next PC: PC+1, PC+2 (skip), a jump target, or halt.
- Sits between instruction memory and the control/datapath.

Parameters:
- PC_WIDTH, 16, width of PC and instruction-memory address (word addressed).
- RESET_PC, 0, PC value loaded on reset.
- CNT_WIDTH, 8, width of the saturating skipped-instruction counter.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- run  in  1  level; permits leaving IDLE and continuing after UPDATE.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_WIDTH  fetch address; always equals PC.
- imem_ready  in  1  fetch data valid this cycle; qualified by imem_req.
- imem_rdata  in  16  instruction word.
- IR  out  16  latched instruction.
- Opcode  out  4  IR[15:12], to miniController.
- funct  out  4  IR[3:0], to miniController.
- ir_valid  out  1  IR holds the instruction currently executing.
- exec_done  in  1  datapath finished execute; qualifies skip/jump/halt.
- skip  in  1  from miniController.
- jump  in  1  unconditional jump request.
- jump_target  in  PC_WIDTH  jump destination.
- halt  in  1  halt request.
- PC  out  PC_WIDTH  program counter.
- state  out  3  current FSM state (debug).
- skip_count  out  CNT_WIDTH  number of skips taken, saturating.

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE(0), PC=RESET_PC, IR=0, ir_valid=0, imem_req=0, skip_count=0.
  - All outputs take these values immediately, not at the next edge.
  - Deassertion is sampled on the next rising edge.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, UPDATE=4, HALTED=5. Codes 6 and 7 go to IDLE on the next edge.
- IDLE: imem_req=0. If run=1, go to FETCH next cycle; otherwise stay.
- FETCH:
  - imem_req=1 (combinational from state); imem_addr=PC.
  - Waits indefinitely for imem_ready.
  - On the edge where imem_ready=1: IR<=imem_rdata, ir_valid<=1, go to DECODE.
- DECODE:
  - Lasts exactly one cycle; IR is stable, so Opcode/funct are stable for miniController.
  - Always goes to EXEC.
- EXEC:
  - Waits for exec_done=1.
  - On that edge, registers skip, jump, jump_target and halt into internal holding registers and goes to UPDATE.
  - skip/jump/halt are ignored in every other cycle.
- UPDATE (one cycle), applied on its edge, priority halt > jump > skip > sequential:
  - halt: PC<=PC+1, go to HALTED.
  - jump: PC<=jump_target. skip_count is not incremented even if skip was also 1.
  - skip: PC<=PC+2; skip_count<=skip_count+1, saturating at all-ones.
  - otherwise: PC<=PC+1.
  - In all cases ir_valid<=0.
  - Next state (non-halt): FETCH if run=1, else IDLE.
- HALTED: imem_req=0, PC frozen, stays until reset. run has no effect.
- Arithmetic: PC add is modulo 2^PC_WIDTH, so PC=0xFFFF with skip gives 0x0001, and PC=0xFFFF sequential gives 0x0000.
- Latency:
  - Minimum 4 cycles per instruction (FETCH with ready on first cycle, DECODE, EXEC with exec_done on first cycle, UPDATE).
  - PC changes only on the UPDATE edge.
- Simultaneous events:
  - imem_ready asserted outside FETCH is ignored.
  - run deasserted mid-instruction does not abort it; the instruction completes and the FSM parks in IDLE with the updated PC.
- Reset mid-operation (any state, including FETCH with a request outstanding): imem_req drops immediately and no partial IR or PC update is retained.

Test Plan:
- Sequential: reset, run=1, ready/exec_done=1 every cycle, imem_rdata=0x0000, skip=0 -> PC 0,1,2,3 at successive UPDATE edges, 4 cycles each; imem_req high only in FETCH.
- Skip path: imem_rdata=0xD000 (Opcode 13), skip=1 at exec_done -> PC 0->2, skip_count=1, Opcode=13 stable through DECODE/EXEC; with skip=0 -> PC 0->1, count unchanged.
- Priority: at PC=5, jump=1, jump_target=0x0040, skip=1 -> PC=0x0040, skip_count unchanged. Repeat with halt=1 also set -> PC=6, state=5; run toggling afterward leaves PC=6.
- Wrap and saturation: force PC=0xFFFF via jump, then skip -> PC=0x0001. With CNT_WIDTH=2, four skips -> skip_count=3.
- Handshake stalls: hold imem_ready=0 for 5 cycles -> state stays 1, imem_addr stable, IR unchanged. Hold exec_done=0 for 3 cycles while toggling skip -> only the value at exec_done is used.
- Async reset in FETCH: pulse Reset_n low mid-cycle between edges -> imem_req=0, PC=RESET_PC, state=0 before the next edge; run=1 restarts the fetch from RESET_PC.
